// File: rtl/word_unpacker_pkg.sv
// Shared CNN packing definitions: element geometry, valid-flag position and
// the unpacker state encoding.
package word_unpacker_pkg;

    localparam int ELEM_W_DEF = 20;
    localparam int ELEMS_DEF  = 3;
    localparam int WORD_W_DEF = 64;
    localparam int VALID_BIT  = WORD_W_DEF - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/elem_slice_mux.sv
// Selects one element of a packed payload by index, oldest (most significant)
// element first, and flags the final element.
module elem_slice_mux
    import word_unpacker_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int ELEMS  = ELEMS_DEF,
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic [ELEMS*ELEM_W-1:0] payload,
    input  logic [IDX_W-1:0]        idx,
    output logic [ELEM_W-1:0]       elem,
    output logic                    last
);

    always_comb begin
        elem = '0;
        last = 1'b0;
        for (int i = 0; i < ELEMS; i++) begin
            if (idx == IDX_W'(i)) begin
                elem = payload[(ELEMS-1-i)*ELEM_W +: ELEM_W];
                last = (i == ELEMS - 1);
            end
        end
    end

endmodule

// File: rtl/word_unpacker.sv
// Reads packed words from a FIFO, drops malformed ones, and streams the
// contained elements oldest first over a valid/ready interface.
module word_unpacker
    import word_unpacker_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int ELEMS  = ELEMS_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_rdata,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err_drop,
    output logic [7:0]        drop_count
);

    localparam int PAY_W = ELEMS * ELEM_W;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int VBIT  = WORD_W - 1;

    unpack_state_t    state, state_nxt;
    logic [PAY_W-1:0] payload_q;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic [7:0]       drop_q;
    logic             rd_req;
    logic             word_ok;
    logic             handshake;
    logic [ELEM_W-1:0] sel_elem;
    logic             sel_last;

    // Bits between the valid flag and the payload must be zero.
    assign word_ok   = fifo_rdata[VBIT] && (fifo_rdata[VBIT-1:PAY_W] == '0);
    assign handshake = (state == EMIT) && out_ready;

    elem_slice_mux #(
        .ELEM_W (ELEM_W),
        .ELEMS  (ELEMS)
    ) u_slice_mux (
        .payload (payload_q),
        .idx     (idx_q),
        .elem    (sel_elem),
        .last    (sel_last)
    );

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = word_ok ? EMIT : IDLE;
            end
            EMIT: begin
                if (handshake && sel_last) begin
                    if (!fifo_empty) begin
                        rd_req    = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            payload_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            err_q <= (state == WAIT) && !word_ok;
            if ((state == WAIT) && !word_ok && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (state == WAIT) begin
                payload_q <= fifo_rdata[PAY_W-1:0];
                idx_q     <= '0;
            end else if (handshake) begin
                idx_q <= sel_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs are forced quiet while reset is held so nothing leaks before the
    // state register has been cleared.
    assign fifo_rd_en = rd_req && reset;
    assign out_valid  = (state == EMIT) && reset;
    assign out_data   = out_valid ? sel_elem : '0;
    assign out_last   = out_valid && sel_last;
    assign err_drop   = err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: FIFO model, handshake monitor and a
// word-level reference model of the expected element stream.
module tb_word_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] fifo_rdata = 64'd0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        err_drop;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] fq[$];
    logic [63:0] pend_word;
    bit          pending = 1'b0;

    int          cyc = 0;
    logic [19:0] hs_data[$];
    bit          hs_last[$];
    int          hs_cyc[$];
    int          rd_cyc[$];
    int          v_cyc[$];
    int          err_pulses = 0;

    logic [19:0] exp_data[$];
    bit          exp_last[$];
    int          exp_drops = 0;

    word_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .err_drop   (err_drop),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // FIFO model: a read strobe seen before a rising edge pops a word whose
    // data is presented for the following rising edge.
    initial forever begin
        @(negedge clk);
        if (pending) begin
            fifo_rdata = pend_word;
            pending = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
        #1;
        if (fifo_rd_en && fq.size() > 0) begin
            pend_word = fq.pop_front();
            pending = 1'b1;
        end
    end

    // Monitor: records what will happen at the next rising edge.
    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        if (reset) begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (out_valid) begin
                v_cyc.push_back(cyc);
                if (out_ready) begin
                    hs_data.push_back(out_data);
                    hs_last.push_back(out_last);
                    hs_cyc.push_back(cyc);
                end
            end
            if (err_drop) err_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    function automatic logic [63:0] mk_word(input logic [3:0] top, input logic [19:0] a,
                                            input logic [19:0] b, input logic [19:0] c);
        return {top, a, b, c};
    endfunction

    // Reference model: a word is kept only if its flag nibble is exactly 8.
    task automatic model_word(input logic [63:0] w);
        if (w[63] && w[62:60] == 3'd0) begin
            for (int k = 0; k < 3; k++) begin
                exp_data.push_back(w[59-20*k -: 20]);
                exp_last.push_back(k == 2);
            end
        end else begin
            exp_drops++;
        end
    endtask

    task automatic send(input logic [63:0] w);
        fq.push_back(w);
        model_word(w);
    endtask

    task automatic clear_log();
        hs_data.delete(); hs_last.delete(); hs_cyc.delete();
        rd_cyc.delete(); v_cyc.delete(); err_pulses = 0;
        exp_data.delete(); exp_last.delete(); exp_drops = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        fq.delete();
        pending = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((hs_data.size() < exp_data.size() || fq.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d elements, required %0d", name, hs_data.size(), exp_data.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        fq.push_back(mk_word(4'h8, 20'h1, 20'h2, 20'h3));
        repeat (3) @(negedge clk);
        checks++;
        if ({fifo_rd_en, out_valid, out_last, err_drop} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000", {fifo_rd_en, out_valid, out_last, err_drop});
        end
        checks++;
        if (out_data !== 20'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: out_data=%h drop_count=%0d, required 0 and 0", out_data, drop_count);
        end
        fq.delete();
        pending = 1'b0;
        reset = 1'b1;
        clear_log();
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        send(mk_word(4'h8, 20'h00001, 20'h00002, 20'h00003));
        wait_done("single", 50);
        checks++;
        if (hs_data.size() !== 3) begin
            errors++;
            $display("FAIL single_count: got %0d, required 3", hs_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL single_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (rd_cyc.size() !== 1) begin
            errors++;
            $display("FAIL single_rd_count: got %0d, required 1", rd_cyc.size());
        end
        if (hs_cyc.size() == 3 && rd_cyc.size() >= 1) begin
            checks++;
            if (hs_cyc[2] - hs_cyc[0] !== 2 || hs_cyc[0] - rd_cyc[0] !== 2) begin
                errors++;
                $display("FAIL single_timing: span %0d latency %0d, required 2 and 2", hs_cyc[2] - hs_cyc[0], hs_cyc[0] - rd_cyc[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++)
            send(mk_word(4'h8, 20'($urandom), 20'($urandom), 20'($urandom)));
        wait_done("b2b", 100);
        checks++;
        if (hs_data.size() !== 12) begin
            errors++;
            $display("FAIL b2b_count: got %0d, required 12", hs_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL b2b_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (rd_cyc.size() !== 4) begin
            errors++;
            $display("FAIL b2b_rd_count: got %0d, required 4", rd_cyc.size());
        end
        for (int i = 1; i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] - rd_cyc[i-1] !== 4) begin
                errors++;
                $display("FAIL b2b_rd_gap%0d: got %0d, required 4", i, rd_cyc[i] - rd_cyc[i-1]);
            end
        end
        if (v_cyc.size() == 12) begin
            checks++;
            if (v_cyc[11] - v_cyc[0] !== 14) begin
                errors++;
                $display("FAIL b2b_duty: 12 valid cycles span %0d, required 14", v_cyc[11] - v_cyc[0]);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        int rd_before;
        apply_reset();
        out_ready = 1'b1;
        send(mk_word(4'h8, 20'h00001, 20'h00002, 20'h00003));
        send(mk_word(4'h8, 20'hABCDE, 20'h12345, 20'hFEDCB));
        n = 0;
        while (hs_data.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        rd_before = rd_cyc.size();
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 20'h00002 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%0b data=%h last=%0b, required 1/00002/0", s, out_valid, out_data, out_last);
            end
        end
        @(negedge clk);
        checks++;
        if (rd_cyc.size() !== rd_before) begin
            errors++;
            $display("FAIL stall_rd: got %0d reads during stall, required 0", rd_cyc.size() - rd_before);
        end
        out_ready = 1'b1;
        wait_done("stall", 60);
        checks++;
        if (hs_data.size() !== 6) begin
            errors++;
            $display("FAIL stall_count: got %0d, required 6", hs_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL stall_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_drops();
        apply_reset();
        out_ready = 1'b1;
        send(mk_word(4'h0, 20'h00001, 20'h00002, 20'h00003));
        send(mk_word(4'hA, 20'h11111, 20'h22222, 20'h33333));
        send(mk_word(4'h8, 20'h44444, 20'h55555, 20'h66666));
        wait_done("drops", 60);
        checks++;
        if (err_pulses !== 2 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL drops_count: pulses=%0d drop_count=%0d, required 2 and 2", err_pulses, drop_count);
        end
        checks++;
        if (hs_data.size() !== 3) begin
            errors++;
            $display("FAIL drops_elems: got %0d, required 3", hs_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL drops_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        out_ready = 1'b1;
        for (int w = 0; w < 260; w++)
            send(mk_word(4'($urandom_range(0, 7)), 20'($urandom), 20'($urandom), 20'($urandom)));
        wait_done("sat", 2000);
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_drop_count: got %0d, required 255", drop_count);
        end
        checks++;
        if (err_pulses !== 260 || hs_data.size() !== 0) begin
            errors++;
            $display("FAIL sat_pulses: pulses=%0d elems=%0d, required 260 and 0", err_pulses, hs_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [63:0] wa, wb;
        apply_reset();
        out_ready = 1'b1;
        wa = mk_word(4'h8, 20'hA0001, 20'hA0002, 20'hA0003);
        wb = mk_word(4'h8, 20'hB0001, 20'hB0002, 20'hB0003);
        fq.push_back(wa);
        fq.push_back(wb);
        exp_data.push_back(20'hA0001); exp_last.push_back(1'b0);
        model_word(wb);
        n = 0;
        while (hs_data.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fifo_rd_en, out_valid, out_last, err_drop} !== 4'b0000 || out_data !== 20'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl=%b data=%h drops=%0d, required 0000/0/0",
                     {fifo_rd_en, out_valid, out_last, err_drop}, out_data, drop_count);
        end
        reset = 1'b1;
        wait_done("midrst", 60);
        checks++;
        if (hs_data.size() !== 4) begin
            errors++;
            $display("FAIL midrst_count: got %0d, required 4", hs_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL midrst_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int kind;
        logic [3:0] top;
        apply_reset();
        for (int w = 0; w < 40; w++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) top = {1'b0, 3'($urandom_range(0, 7))};
            else if (kind == 1) top = {1'b1, 3'($urandom_range(1, 7))};
            else top = 4'h8;
            send(mk_word(top, 20'($urandom), 20'($urandom), 20'($urandom)));
        end
        n = 0;
        while ((hs_data.size() < exp_data.size() || fq.size() > 0) && n < 1500) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        out_ready = 1'b1;
        wait_done("rand", 100);
        checks++;
        if (hs_data.size() !== exp_data.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d, required %0d", hs_data.size(), exp_data.size());
        end
        for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (hs_data[i] !== exp_data[i] || hs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL rand_elem%0d: got %h/%0b, required %h/%0b", i, hs_data[i], hs_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (err_pulses !== exp_drops || drop_count !== 8'(exp_drops)) begin
            errors++;
            $display("FAIL rand_drops: pulses=%0d drop_count=%0d, required %0d", err_pulses, drop_count, exp_drops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drops();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
